unified_mem: RTL

- Single-port unified instruction/data memory with a small memory-mapped I/O window.
- Sits directly downstream of the multicycle RISC-V core and consumes its memory bus (address, write strobe, write data, funct3). Returns registered read data one cycle later.
- Handles RV32I sub-word loads and stores: lb/lh/lw/lbu/lhu and sb/sh/sw.
- Provides an LED register, a free-running cycle counter and a sticky misalignment flag.

---
 rtl/unified_mem.sv | 115 +++++++++++
 1 files changed

// File: rtl/unified_mem.sv
// Unified instruction/data memory with LED, cycle counter and misalignment flag.
// Registered read data, RV32I sub-word loads and stores.
module unified_mem #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
    parameter string       INIT_FILE = "program.hex"
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Adr,
    input  logic        MemWrite,
    input  logic [31:0] WriteData,
    input  logic [2:0]  funct3,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        err_misaligned
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(MEM_WORDS) << 2;

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   cycle;
    logic [AW-1:0] idx;
    logic          ram_hit;
    logic          mmio_hit;
    logic [3:0]    st_be;
    logic [31:0]   st_data;
    logic          st_mis;
    logic          do_wr;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   rd_fmt;

    assign idx      = Adr[AW+1:2];
    assign ram_hit  = {1'b0, Adr} < RAM_BYTES;
    assign mmio_hit = Adr[31:4] == MMIO_BASE[31:4];

    // Store lane enables, replicated data and misalignment detection
    always_comb begin
        st_be   = 4'b0000;
        st_data = {4{WriteData[7:0]}};
        st_mis  = 1'b0;
        case (funct3)
            3'b000: st_be = 4'b0001 << Adr[1:0];
            3'b001: begin
                st_data = {2{WriteData[15:0]}};
                if (Adr[0]) st_mis = 1'b1;
                else        st_be  = Adr[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                st_data = WriteData;
                if (|Adr[1:0]) st_mis = 1'b1;
                else           st_be  = 4'b1111;
            end
            default: ;
        endcase
    end

    assign do_wr = MemWrite & rst & ~st_mis;

    // Source word selection: RAM, I/O registers or zero
    always_comb begin
        rd_word = '0;
        if (ram_hit) begin
            rd_word = mem[idx];
        end else if (mmio_hit) begin
            case (Adr[3:2])
                2'd0:    rd_word = {24'b0, leds};
                2'd1:    rd_word = cycle;
                default: rd_word = '0;
            endcase
        end
    end

    // Load formatting by size and signedness
    always_comb begin
        rd_byte = rd_word[{Adr[1:0], 3'b000} +: 8];
        rd_half = Adr[1] ? rd_word[31:16] : rd_word[15:0];
        case (funct3)
            3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_fmt = {24'b0, rd_byte};
            3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_fmt = {16'b0, rd_half};
            default: rd_fmt = rd_word;
        endcase
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (do_wr && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

    // Read register, cycle counter, LED register and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ReadData       <= '0;
            leds           <= '0;
            cycle          <= '0;
            err_misaligned <= 1'b0;
        end else begin
            ReadData <= rd_fmt;
            cycle    <= cycle + 32'd1;
            if (MemWrite && st_mis) err_misaligned <= 1'b1;
            if (do_wr && mmio_hit && Adr[3:2] == 2'd0 && st_be[0])
                leds <= st_data[7:0];
        end
    end

endmodule
